branch_resolve_unit: RTL

- Consumer side of the branch comparator in the 5-stage RV32I pipeline.
- Takes the EX-stage compare flags (less/equal) with funct3 and decides taken / not-taken.
- Drives the comparator's unsigned-select back, keeps a small 2-bit BHT queried by fetch, and issues registered PC redirect plus multi-cycle flush on mispredict.

---
 rtl/branch_resolve_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves EX-stage conditional branches and jumps,
// keeps a table of 2-bit saturating counters used by fetch for direction
// prediction, and issues a registered PC redirect plus a multi-cycle IF/ID
// flush when the carried prediction turns out wrong.
// Optional macro BRU_PERF_EN adds branch/mispredict performance counters.
module branch_resolve_unit #(
  parameter int BHT_ENTRIES  = 16,
  parameter int IDX_W        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_f_pc,
  output logic        o_f_pred_taken,
  input  logic        i_stall,
  input  logic        i_e_valid,
  input  logic        i_e_is_branch,
  input  logic        i_e_is_jump,
  input  logic [2:0]  i_e_funct3,
  input  logic        i_e_br_less,
  input  logic        i_e_br_equal,
  input  logic        i_e_pred_taken,
  input  logic [31:0] i_e_pc,
  input  logic [31:0] i_e_target,
  output logic        o_br_un,
  output logic        o_e_taken,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush
`ifdef BRU_PERF_EN
  ,
  output logic [31:0] o_perf_branches,
  output logic [31:0] o_perf_mispredicts
`endif
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [1:0] CTR_RESET  = 2'b01;  // weakly not-taken

  logic [1:0]       bht [BHT_ENTRIES];
  logic [2:0]       flush_cnt;
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] e_idx;
  logic             br_legal;
  logic             resolve;
  logic             mispredict;
  logic             bht_we;
  logic             unused_pc_bits;

  assign f_idx = i_f_pc[IDX_W+1:2];
  assign e_idx = i_e_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{i_f_pc[31:IDX_W+2], i_f_pc[1:0]};

  // Prediction is a plain read of the registered table: a write landing on
  // the same index this cycle is seen only from the next cycle on.
  assign o_f_pred_taken = bht[f_idx][1];

  // Unsigned compare is selected by funct3[1] (BLTU/BGEU).
  assign o_br_un = i_e_funct3[1];

  // Decode the resolved direction from the comparator flags and funct3.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    o_e_taken = 1'b0;
    br_legal  = 1'b0;
    if (i_e_is_jump) begin
      o_e_taken = 1'b1;
    end else if (i_e_is_branch) begin
      br_legal = 1'b1;
      case (i_e_funct3)
        3'b000:         o_e_taken = i_e_br_equal;
        3'b001:         o_e_taken = !i_e_br_equal;
        3'b100, 3'b110: o_e_taken = i_e_br_less;
        3'b101, 3'b111: o_e_taken = !i_e_br_less;
        default:        br_legal  = 1'b0;
      endcase
    end
  end

  // Wrong-path instructions behind a redirect are ignored until the flush ends.
  assign resolve    = i_e_valid && (i_e_is_branch || i_e_is_jump) && !i_stall
                      && !o_flush && (flush_cnt == 3'd0);
  assign mispredict = resolve && (i_e_is_jump || br_legal)
                      && (o_e_taken != i_e_pred_taken);
  assign bht_we     = resolve && !i_e_is_jump && br_legal;

  // Saturating counter update for resolved legal conditional branches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the table is reset entry by entry so prediction starts from a known weak state.
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_RESET;
    end else if (bht_we) begin
      // NOTE: non-blocking assignment keeps the lookup above on the pre-update value.
      if (o_e_taken) begin
        if (bht[e_idx] != 2'b11) bht[e_idx] <= bht[e_idx] + 2'b01;
      end else begin
        if (bht[e_idx] != 2'b00) bht[e_idx] <= bht[e_idx] - 2'b01;
      end
    end
  end

  // Redirect pulse, correct next PC and flush window after a mispredict.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_redirect    <= 1'b0;
      o_redirect_pc <= 32'h0;
      o_flush       <= 1'b0;
      flush_cnt     <= 3'd0;
    end else begin
      o_redirect <= mispredict;
      if (mispredict) begin
        o_redirect_pc <= o_e_taken ? i_e_target : i_e_pc + 32'd4;
        o_flush       <= 1'b1;
        flush_cnt     <= FLUSH_LOAD;
      end else begin
        // The flush window runs down even while the pipe is stalled.
        o_flush <= (flush_cnt != 3'd0);
        if (flush_cnt != 3'd0) flush_cnt <= flush_cnt - 3'd1;
      end
    end
  end

`ifdef BRU_PERF_EN
  // Free-running wrap-around counters of resolutions and mispredicts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_perf_branches    <= 32'h0;
      o_perf_mispredicts <= 32'h0;
    end else begin
      if (resolve)    o_perf_branches    <= o_perf_branches + 32'd1;
      if (mispredict) o_perf_mispredicts <= o_perf_mispredicts + 32'd1;
    end
  end
`endif

endmodule
